// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds renamed instructions, wakes operands from the
// physical-register valid vector and issues the oldest ready entry per cycle.
module issue_queue #(
    parameter int SLOTS     = 8,
    parameter int PREGS     = 128,
    parameter int PAYLOAD_W = 64,
    parameter int TAG_W     = $clog2(PREGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [PREGS-1:0]           register_valid,
    input  logic [PAYLOAD_W-1:0]       instruction_i,
    input  logic [TAG_W-1:0]           src1_i,
    input  logic [TAG_W-1:0]           src2_i,
    input  logic                       src1_en_i,
    input  logic                       src2_en_i,
    input  logic                       valid_i,
    output logic                       ready_i,
    output logic [PAYLOAD_W-1:0]       instruction_o,
    output logic                       valid_o,
    input  logic                       ready_o,
    output logic [$clog2(SLOTS+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam int IDX_W = $clog2(SLOTS);

    logic [SLOTS-1:0]     valid_q;
    logic [SLOTS-1:0]     rdy1_q;
    logic [SLOTS-1:0]     rdy2_q;
    logic [IDX_W-1:0]     age_q     [SLOTS];
    logic [PAYLOAD_W-1:0] payload_q [SLOTS];
    logic [TAG_W-1:0]     tag1_q    [SLOTS];
    logic [TAG_W-1:0]     tag2_q    [SLOTS];
    logic [CNT_W-1:0]     count_q;
    logic                 ready_q;
    logic                 lock_q;
    logic [IDX_W-1:0]     lock_idx_q;

    logic [SLOTS-1:0]     eff1;
    logic [SLOTS-1:0]     eff2;
    logic [SLOTS-1:0]     cand;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     best_age;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 enq;
    logic                 deq;
    logic [CNT_W-1:0]     count_nxt;
    logic [IDX_W-1:0]     new_age;

    // Readiness includes this cycle's register_valid so wakeup and issue overlap.
    always_comb begin
        eff1 = '0;
        eff2 = '0;
        cand = '0;
        for (int i = 0; i < SLOTS; i++) begin
            eff1[i] = rdy1_q[i] | register_valid[tag1_q[i]];
            eff2[i] = rdy2_q[i] | register_valid[tag2_q[i]];
            cand[i] = valid_q[i] & eff1[i] & eff2[i];
        end
    end

    // Oldest candidate wins (lowest age rank); a locked entry overrides it.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (cand[i] && (!sel_found || age_q[i] < best_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age_q[i];
            end
        end
        if (lock_q) begin
            sel_found = 1'b1;
            sel_idx   = lock_idx_q;
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign valid_o       = sel_found && !flush;
    assign instruction_o = payload_q[sel_idx];
    assign ready_i       = ready_q;
    assign count_o       = count_q;

    assign enq       = valid_i && ready_q && !flush && free_found;
    assign deq       = valid_o && ready_o;
    assign count_nxt = count_q + CNT_W'(enq) - CNT_W'(deq);
    assign new_age   = IDX_W'(count_q - CNT_W'(deq));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            rdy1_q     <= '0;
            rdy2_q     <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            for (int i = 0; i < SLOTS; i++) age_q[i] <= '0;
        end else if (flush) begin
            valid_q <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            lock_q  <= 1'b0;
        end else begin
            rdy1_q <= eff1;
            rdy2_q <= eff2;
            // Closing the gap left by the issued entry keeps ranks dense and ordered.
            for (int i = 0; i < SLOTS; i++) begin
                if (deq && valid_q[i] && age_q[i] > age_q[sel_idx])
                    age_q[i] <= age_q[i] - 1'b1;
            end
            if (deq) valid_q[sel_idx] <= 1'b0;
            if (enq) begin
                valid_q[free_idx] <= 1'b1;
                rdy1_q[free_idx]  <= !src1_en_i | register_valid[src1_i];
                rdy2_q[free_idx]  <= !src2_en_i | register_valid[src2_i];
                age_q[free_idx]   <= new_age;
            end
            count_q    <= count_nxt;
            ready_q    <= count_nxt < CNT_W'(SLOTS);
            lock_q     <= valid_o && !ready_o;
            lock_idx_q <= sel_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            payload_q[free_idx] <= instruction_i;
            tag1_q[free_idx]    <= src1_i;
            tag2_q[free_idx]    <= src2_i;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: reset, out-of-order issue, pulse wakeup,
// lock, full/backpressure, flush and asynchronous reset.
module tb_issue_queue;

    localparam int SLOTS     = 4;
    localparam int PREGS     = 16;
    localparam int PAYLOAD_W = 16;
    localparam int TAG_W     = 4;

    logic                 clk;
    logic                 reset;
    logic                 flush;
    logic [PREGS-1:0]     register_valid;
    logic [PAYLOAD_W-1:0] instruction_i;
    logic [TAG_W-1:0]     src1_i;
    logic [TAG_W-1:0]     src2_i;
    logic                 src1_en_i;
    logic                 src2_en_i;
    logic                 valid_i;
    logic                 ready_i;
    logic [PAYLOAD_W-1:0] instruction_o;
    logic                 valid_o;
    logic                 ready_o;
    logic [2:0]           count_o;

    int checks   = 0;
    int failures = 0;

    issue_queue #(
        .SLOTS(SLOTS), .PREGS(PREGS), .PAYLOAD_W(PAYLOAD_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .register_valid(register_valid),
        .instruction_i(instruction_i), .src1_i(src1_i), .src2_i(src2_i),
        .src1_en_i(src1_en_i), .src2_en_i(src2_en_i), .valid_i(valid_i),
        .ready_i(ready_i), .instruction_o(instruction_o), .valid_o(valid_o),
        .ready_o(ready_o), .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] p, input logic [3:0] s1, input logic e1,
                       input logic [3:0] s2, input logic e2);
        valid_i       = 1'b1;
        instruction_i = p;
        src1_i        = s1;
        src1_en_i     = e1;
        src2_i        = s2;
        src2_en_i     = e2;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; register_valid = '0; instruction_i = '0;
        src1_i = '0; src2_i = '0; src1_en_i = 1'b0; src2_en_i = 1'b0;
        valid_i = 1'b0; ready_o = 1'b0;

        #3;
        check("rst_ready", ready_i, 0);
        check("rst_valid", valid_o, 0);
        check("rst_count", count_o, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rel_ready", ready_i, 1);

        // Basic enqueue then issue
        ready_o = 1'b1;
        put(16'hA001, 0, 0, 0, 0);
        tick();
        valid_i = 1'b0;
        #2;
        check("basic_valid", valid_o, 1);
        check("basic_instr", instruction_o, 16'hA001);
        check("basic_count1", count_o, 1);
        tick();
        #2;
        check("basic_count0", count_o, 0);
        check("basic_empty", valid_o, 0);

        // Out-of-order issue and pulse wakeup
        ready_o = 1'b0;
        put(16'h0A0A, 5, 1, 0, 0);
        tick();
        #2;
        check("ooo_a_notready", valid_o, 0);
        put(16'h0B0B, 0, 0, 0, 0);
        tick();
        put(16'h0C0C, 5, 1, 0, 0);
        #2;
        check("ooo_b_first", instruction_o, 16'h0B0B);
        tick();
        valid_i = 1'b0;
        #2;
        check("ooo_count3", count_o, 3);
        ready_o = 1'b1;
        tick();
        #2;
        check("ooo_count2", count_o, 2);
        check("ooo_wait", valid_o, 0);
        register_valid = 16'h0020;
        #2;
        check("ooo_wake_valid", valid_o, 1);
        check("ooo_a_issue", instruction_o, 16'h0A0A);
        tick();
        register_valid = '0;
        #2;
        check("ooo_sticky_valid", valid_o, 1);
        check("ooo_c_issue", instruction_o, 16'h0C0C);
        tick();
        ready_o = 1'b0;
        #2;
        check("ooo_count0", count_o, 0);

        // Lock: younger Y presented and stalled, older X wakes up later
        put(16'h1111, 0, 0, 7, 1);
        tick();
        put(16'h2222, 0, 0, 0, 0);
        tick();
        valid_i = 1'b0;
        #2;
        check("lock_y_first", instruction_o, 16'h2222);
        tick();
        register_valid = 16'h0080;
        #2;
        check("lock_hold", instruction_o, 16'h2222);
        tick();
        register_valid = '0;
        ready_o = 1'b1;
        #2;
        check("lock_hold2", instruction_o, 16'h2222);
        tick();
        #2;
        check("lock_x_valid", valid_o, 1);
        check("lock_x_issue", instruction_o, 16'h1111);
        tick();
        ready_o = 1'b0;
        #2;
        check("lock_count0", count_o, 0);

        // Full and backpressure
        for (int k = 0; k < 4; k++) begin
            put(16'hF000 + 16'(k), 9, 1, 0, 0);
            tick();
        end
        put(16'hF004, 9, 1, 0, 0);
        #2;
        check("full_count", count_o, 4);
        check("full_ready", ready_i, 0);
        tick();
        #2;
        check("full_hold_count", count_o, 4);
        register_valid = 16'h0200;
        ready_o = 1'b1;
        #2;
        check("full_oldest", instruction_o, 16'hF000);
        tick();
        register_valid = '0;
        ready_o = 1'b0;
        #2;
        check("full_after_deq", count_o, 3);
        check("full_ready_again", ready_i, 1);
        tick();
        valid_i = 1'b0;
        #2;
        check("full_fifth_in", count_o, 4);
        check("full_ready_low", ready_i, 0);
        ready_o = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #2;
            check("full_drain", instruction_o, 16'hF000 + 16'(k));
            tick();
        end
        ready_o = 1'b0;
        #2;
        check("full_left", count_o, 1);
        check("full_f4_wait", valid_o, 0);

        // Flush drops queue contents and the concurrent enqueue
        put(16'h3330, 0, 0, 0, 0);
        tick();
        put(16'h3331, 0, 0, 0, 0);
        tick();
        valid_i = 1'b0;
        #2;
        check("flush_pre_count", count_o, 3);
        put(16'h3332, 0, 0, 0, 0);
        ready_o = 1'b1;
        flush = 1'b1;
        #2;
        check("flush_valid", valid_o, 0);
        tick();
        flush = 1'b0;
        valid_i = 1'b0;
        ready_o = 1'b0;
        #2;
        check("flush_count", count_o, 0);
        check("flush_empty", valid_o, 0);
        check("flush_ready", ready_i, 1);
        tick();
        #2;
        check("flush_dropped", count_o, 0);

        // Asynchronous reset mid-cycle
        put(16'h4440, 0, 0, 0, 0);
        tick();
        put(16'h4441, 0, 0, 0, 0);
        tick();
        valid_i = 1'b0;
        #2;
        check("ar_pre_count", count_o, 2);
        check("ar_pre_valid", valid_o, 1);
        reset = 1'b1;
        #1;
        check("ar_valid", valid_o, 0);
        check("ar_count", count_o, 0);
        check("ar_ready", ready_i, 0);
        tick();
        reset = 1'b0;
        tick();
        #2;
        check("ar_rel_ready", ready_i, 1);
        check("ar_rel_valid", valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
